// File: rtl/axi4_lite_master_engine.sv
// Purpose: single-outstanding AXI4-Lite master fed by a valid/ready command port, with a per-phase timeout and abort.
// Latency: 3 cycles from command accept to rsp_valid_out against a zero-wait slave. Every output is registered.
// Backpressure: cmd_ready_out is high only in IDLE. The response is held stable until rsp_ready_in. A hung phase aborts after TIMEOUT_CLKS.
// Ports: clk_in/rst_in are the clock and the synchronous active-high reset.
//   cmd_* is the command input (write/addr/wdata/wstrb). rsp_* is the response output (rdata/resp/timeout).
//   m_axi_* are the AW/W/B/AR/R master channels. AWPROT and ARPROT are not provided.
module axi4_lite_master_engine #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 32,
  parameter int TIMEOUT_CLKS = 100
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   cmd_valid_in,
  output logic                   cmd_ready_out,
  input  logic                   cmd_write_in,
  input  logic [ADDRWIDTH-1:0]   cmd_addr_in,
  input  logic [DATAWIDTH-1:0]   cmd_wdata_in,
  input  logic [DATAWIDTH/8-1:0] cmd_wstrb_in,
  output logic                   rsp_valid_out,
  input  logic                   rsp_ready_in,
  output logic [DATAWIDTH-1:0]   rsp_rdata_out,
  output logic [1:0]             rsp_resp_out,
  output logic                   rsp_timeout_out,
  output logic [ADDRWIDTH-1:0]   m_axi_awaddr_out,
  output logic                   m_axi_awvalid_out,
  input  logic                   m_axi_awready_in,
  output logic [DATAWIDTH-1:0]   m_axi_wdata_out,
  output logic [DATAWIDTH/8-1:0] m_axi_wstrb_out,
  output logic                   m_axi_wvalid_out,
  input  logic                   m_axi_wready_in,
  input  logic [1:0]             m_axi_bresp_in,
  input  logic                   m_axi_bvalid_in,
  output logic                   m_axi_bready_out,
  output logic [ADDRWIDTH-1:0]   m_axi_araddr_out,
  output logic                   m_axi_arvalid_out,
  input  logic                   m_axi_arready_in,
  input  logic [DATAWIDTH-1:0]   m_axi_rdata_in,
  input  logic [1:0]             m_axi_rresp_in,
  input  logic                   m_axi_rvalid_in,
  output logic                   m_axi_rready_out
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                   cmd_ready_d, rsp_valid_d, rsp_timeout_d;
  logic [DATAWIDTH-1:0]   rsp_rdata_d, wdata_d;
  logic [1:0]             rsp_resp_d;
  logic [ADDRWIDTH-1:0]   awaddr_d, araddr_d;
  logic [DATAWIDTH/8-1:0] wstrb_d;
  logic                   awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic                   in_phase, expired, aw_hs, w_hs;

  assign in_phase = (state_q == WR_AW_W) || (state_q == WR_B) ||
                    (state_q == RD_AR)   || (state_q == RD_R);
  // The phase has been open for TIMEOUT_CLKS cycles at this edge. A handshake
  // on the same edge is checked first, so it takes priority over the abort.
  assign expired  = (cnt_q == CW'(TIMEOUT_CLKS - 1));
  assign aw_hs    = m_axi_awvalid_out & m_axi_awready_in;
  assign w_hs     = m_axi_wvalid_out & m_axi_wready_in;

  always_comb begin
    state_d       = state_q;
    cnt_d         = in_phase ? cnt_q + CW'(1) : cnt_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    cmd_ready_d   = cmd_ready_out;
    rsp_valid_d   = rsp_valid_out;
    rsp_rdata_d   = rsp_rdata_out;
    rsp_resp_d    = rsp_resp_out;
    rsp_timeout_d = rsp_timeout_out;
    awaddr_d      = m_axi_awaddr_out;
    wdata_d       = m_axi_wdata_out;
    wstrb_d       = m_axi_wstrb_out;
    araddr_d      = m_axi_araddr_out;
    awvalid_d     = m_axi_awvalid_out;
    wvalid_d      = m_axi_wvalid_out;
    bready_d      = m_axi_bready_out;
    arvalid_d     = m_axi_arvalid_out;
    rready_d      = m_axi_rready_out;

    case (state_q)
      IDLE: begin
        if (cmd_valid_in && cmd_ready_out) begin
          cmd_ready_d = 1'b0;
          if (cmd_write_in) begin
            awaddr_d  = cmd_addr_in;
            wdata_d   = cmd_wdata_in;
            wstrb_d   = cmd_wstrb_in;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_AW_W;
          end else begin
            araddr_d  = cmd_addr_in;
            arvalid_d = 1'b1;
            state_d   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        // AW and W retire independently. Each valid drops right after its own handshake.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_B;
        end else if (expired) begin
          state_d = RESP;
        end
      end
      WR_B: begin
        if (m_axi_bready_out && m_axi_bvalid_in) begin
          bready_d      = 1'b0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi_bresp_in;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (expired) begin
          state_d = RESP;
        end
      end
      RD_AR: begin
        if (m_axi_arready_in) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end else if (expired) begin
          state_d = RESP;
        end
      end
      RD_R: begin
        if (m_axi_rvalid_in) begin
          rready_d      = 1'b0;
          rsp_rdata_d   = m_axi_rdata_in;
          rsp_resp_d    = m_axi_rresp_in;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (expired) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_in) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A phase state jumping straight to RESP without posting a response is an abort.
    // This drops every AXI valid/ready, even before its handshake, so a hung slave
    // cannot stall the engine forever.
    if (in_phase && (state_d == RESP) && !rsp_valid_d) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      rsp_valid_d   = 1'b1;
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      aw_done_q         <= 1'b0;
      w_done_q          <= 1'b0;
      cmd_ready_out     <= 1'b1;
      rsp_valid_out     <= 1'b0;
      rsp_rdata_out     <= '0;
      rsp_resp_out      <= 2'b00;
      rsp_timeout_out   <= 1'b0;
      m_axi_awaddr_out  <= '0;
      m_axi_wdata_out   <= '0;
      m_axi_wstrb_out   <= '0;
      m_axi_araddr_out  <= '0;
      m_axi_awvalid_out <= 1'b0;
      m_axi_wvalid_out  <= 1'b0;
      m_axi_bready_out  <= 1'b0;
      m_axi_arvalid_out <= 1'b0;
      m_axi_rready_out  <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      aw_done_q         <= aw_done_d;
      w_done_q          <= w_done_d;
      cmd_ready_out     <= cmd_ready_d;
      rsp_valid_out     <= rsp_valid_d;
      rsp_rdata_out     <= rsp_rdata_d;
      rsp_resp_out      <= rsp_resp_d;
      rsp_timeout_out   <= rsp_timeout_d;
      m_axi_awaddr_out  <= awaddr_d;
      m_axi_wdata_out   <= wdata_d;
      m_axi_wstrb_out   <= wstrb_d;
      m_axi_araddr_out  <= araddr_d;
      m_axi_awvalid_out <= awvalid_d;
      m_axi_wvalid_out  <= wvalid_d;
      m_axi_bready_out  <= bready_d;
      m_axi_arvalid_out <= arvalid_d;
      m_axi_rready_out  <= rready_d;
    end
  end

endmodule

// File: doc/axi4_lite_master_engine.md
# axi4_lite_master_engine

Synthesisable, parametrised AXI4-Lite master that turns single-beat read/write commands from a simple valid/ready command port into AXI4-Lite transactions, returning data and status on a response port. It sits between register-access logic (or a testbench command driver) and any AXI4-Lite slave, replacing blocking simulation tasks with a clocked engine. Compared with the earlier task-based master it adds concurrent AW/W issue, a per-phase timeout with abort, and a response handshake.

## Interface
- DATAWIDTH, 32, AXI data width; 32 or 64 only
- ADDRWIDTH, 32, AXI address width, 12..64
- TIMEOUT_CLKS, 100, maximum wait cycles per handshake phase, >= 2
- clk_in  in  1  clock; all logic rising-edge
- rst_in  in  1  reset; synchronous, active-high
- cmd_valid_in  in  1  command present
- cmd_ready_out  out  1  engine idle, command accepted on valid&ready
- cmd_write_in  in  1  1 = write, 0 = read
- cmd_addr_in  in  ADDRWIDTH  target address
- cmd_wdata_in  in  DATAWIDTH  write data (ignored for reads)
- cmd_wstrb_in  in  DATAWIDTH/8  write byte strobes
- rsp_valid_out  out  1  response present
- rsp_ready_in  in  1  response consumed on valid&ready
- rsp_rdata_out  out  DATAWIDTH  read data; 0 for writes and aborted reads
- rsp_resp_out  out  2  BRESP/RRESP; 2'b10 on timeout
- rsp_timeout_out  out  1  phase timed out
- m_axi_awaddr_out/awvalid_out/awready_in, m_axi_wdata_out/wstrb_out/wvalid_out/wready_in, m_axi_bresp_in/bvalid_in/bready_out, m_axi_araddr_out/arvalid_out/arready_in, m_axi_rdata_in/rresp_in/rvalid_in/rready_out: standard AXI4-Lite master signals; AWPROT/ARPROT not provided (slaves tie 3'b000)

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE: cmd_ready_out=1. On accept, register addr/wdata/wstrb; write -> WR_AW_W, read -> RD_AR.
- WR_AW_W: awvalid and wvalid both asserted; each drops the cycle after its own handshake, independently; internal done flags per channel. Both done -> WR_B.
- WR_B: bready=1; on bvalid capture bresp -> RESP.
- RD_AR: arvalid=1 until arready -> RD_R.
- RD_R: rready=1; on rvalid capture rdata, rresp -> RESP.
- RESP: rsp_valid_out=1, outputs stable until rsp_ready_in -> IDLE.
- Timeout: counter (width clog2(TIMEOUT_CLKS+1)) cleared on every state entry, increments each cycle in WR_AW_W/WR_B/RD_AR/RD_R. After TIMEOUT_CLKS cycles without completing the phase: drop all AXI valid/ready, rsp_resp_out=2'b10, rsp_timeout_out=1, rsp_rdata_out=0, -> RESP. Dropping valid before handshake is a deliberate recovery action against a hung slave.
- No outstanding transactions beyond one; no reordering.

## Timing
- Reset: state IDLE; cmd_ready_out=1; rsp_valid_out=0, rsp_rdata_out=0, rsp_resp_out=0, rsp_timeout_out=0; all m_axi valid/ready outputs 0, addr/data/strb 0.
- All outputs registered; no combinational path from any input to any output.
- Command accepted at edge N: AXI valids high from cycle N+1.
- Write, slave always ready: AW/W handshake N+1, bready N+2, bvalid at N+2 -> rsp_valid_out N+3. Read: AR N+1, R N+2, rsp N+3.
- AW and W handshakes in different cycles: WR_B entered the cycle after the later one.
- Response and next command: cmd_ready_out high the cycle after rsp valid&ready.
- Timeout in a phase entered at cycle T with no handshake: valids low and rsp_valid_out high at T+TIMEOUT_CLKS.
- Handshake in the same cycle the counter expires: handshake wins, no timeout.
- rst_in mid-transaction: next edge returns to reset values; captured command discarded; no response issued.

## Test plan
- Write 0x0000_0010 <- 0xDEADBEEF, wstrb 0xF, slave always ready, bresp 0 -> AW/W at N+1, rsp_valid N+3, resp 0, timeout 0.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, single bready phase, resp 0.
- Read 0x0000_0020, slave returns 0x12345678 rresp 2'b10 after 5 cycles -> rsp_rdata 0x12345678, resp 2'b10, timeout 0.
- Read, slave never asserts arready, TIMEOUT_CLKS=8 -> arvalid low after 8 cycles, rsp resp 2'b10, timeout 1, rdata 0; next command accepted normally.
- rsp_ready_in held low 10 cycles -> rsp outputs stable, cmd_ready_out 0 throughout.
- rst_in asserted in WR_B -> next edge all valids 0, cmd_ready_out 1, no rsp_valid_out.
